// File: rtl/memory_word_access_unit_pkg.sv
// rtl/memory_word_access_unit_pkg.sv - shared state encoding and width constants for the word access unit
package memory_word_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LO   = 2'b01,
    ST_HI   = 2'b10,
    ST_FIN  = 2'b11
  } mwau_state_e;

  localparam int MEM_LATENCY_MAX = 4;
  localparam int BYTE_W          = 8;
  localparam int WORD_W          = 16;
  localparam int CNT_W           = $clog2(MEM_LATENCY_MAX);

endpackage

// File: rtl/memory_word_access_unit_if.sv
// rtl/memory_word_access_unit_if.sv - control handshake and byte memory bus of the word access unit
// MWAU_ALIGN_CHECK_EN adds the align_err status signal.
interface memory_word_access_unit_if #(
  parameter int ADDR_WIDTH = 16
);
  import memory_word_access_unit_pkg::*;

  logic                  start;
  logic                  write;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WORD_W-1:0]     wdata;
  logic                  busy;
  logic                  done;
  logic [WORD_W-1:0]     rdata;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [BYTE_W-1:0]     mem_data_out;
  logic [BYTE_W-1:0]     mem_data_in;
  logic                  mem_cs;
  logic                  mem_wr;
`ifdef MWAU_ALIGN_CHECK_EN
  logic                  align_err;

  modport master (
    output start, write, addr, wdata, mem_data_in,
    input  busy, done, rdata, mem_addr, mem_data_out, mem_cs, mem_wr, align_err
  );

  modport slave (
    input  start, write, addr, wdata, mem_data_in,
    output busy, done, rdata, mem_addr, mem_data_out, mem_cs, mem_wr, align_err
  );
`else
  modport master (
    output start, write, addr, wdata, mem_data_in,
    input  busy, done, rdata, mem_addr, mem_data_out, mem_cs, mem_wr
  );

  modport slave (
    input  start, write, addr, wdata, mem_data_in,
    output busy, done, rdata, mem_addr, mem_data_out, mem_cs, mem_wr
  );
`endif

endinterface

// File: rtl/mwau_wait_counter.sv
// rtl/mwau_wait_counter.sv - per-byte memory latency down-counter, zero flag marks the last wait cycle
module mwau_wait_counter
  import memory_word_access_unit_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LATENCY - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (en && !zero) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/memory_word_access_unit.sv
// rtl/memory_word_access_unit.sv - 16-bit word read/write over an 8-bit memory as two little-endian byte accesses
// MWAU_ALIGN_CHECK_EN rejects odd word addresses with an align_err pulse.
module memory_word_access_unit
  import memory_word_access_unit_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  memory_word_access_unit_if.slave     bus
);

  mwau_state_e           state, nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WORD_W-1:0]     wdata_q;
  logic                  write_q;
  logic [BYTE_W-1:0]     stage_lo;
  logic [WORD_W-1:0]     rdata_q;
  logic                  accept;
  logic                  misaligned;
  logic                  cnt_load;
  logic                  cnt_en;
  logic                  cnt_zero;
  logic                  align_q;

`ifdef MWAU_ALIGN_CHECK_EN
  assign misaligned = bus.addr[0];
`else
  assign misaligned = 1'b0;
`endif

  mwau_wait_counter #(.MEM_LATENCY(MEM_LATENCY)) u_wait (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .en   (cnt_en),
    .zero (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt;
  end

  // The same counter is reloaded on entry to LO and again on entry to HI.
  always_comb begin
    nxt      = state;
    accept   = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start && !misaligned) begin
          accept   = 1'b1;
          cnt_load = 1'b1;
          nxt      = ST_LO;
        end
      end
      ST_LO: begin
        cnt_en = 1'b1;
        if (cnt_zero) begin
          cnt_load = 1'b1;
          nxt      = ST_HI;
        end
      end
      ST_HI: begin
        cnt_en = 1'b1;
        if (cnt_zero) nxt = ST_FIN;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      stage_lo <= '0;
      rdata_q  <= '0;
      align_q  <= 1'b0;
    end else begin
      align_q <= (state == ST_IDLE) && bus.start && misaligned;
      if (accept) begin
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        write_q <= bus.write;
      end
      if (state == ST_LO && cnt_zero && !write_q) stage_lo <= bus.mem_data_in;
      // Both bytes land together so rdata never shows a half-updated word.
      if (state == ST_HI && cnt_zero && !write_q) rdata_q <= {bus.mem_data_in, stage_lo};
    end
  end

  always_comb begin
    bus.mem_cs       = 1'b0;
    bus.mem_wr       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_data_out = '0;
    case (state)
      ST_LO: begin
        bus.mem_cs       = 1'b1;
        bus.mem_wr       = write_q;
        bus.mem_addr     = addr_q;
        bus.mem_data_out = wdata_q[BYTE_W-1:0];
      end
      ST_HI: begin
        bus.mem_cs       = 1'b1;
        bus.mem_wr       = write_q;
        bus.mem_addr     = addr_q + ADDR_WIDTH'(1);
        bus.mem_data_out = wdata_q[WORD_W-1:BYTE_W];
      end
      default: ;
    endcase
  end

  assign bus.busy  = (state != ST_IDLE);
  assign bus.done  = (state == ST_FIN) || align_q;
  assign bus.rdata = rdata_q;
`ifdef MWAU_ALIGN_CHECK_EN
  assign bus.align_err = align_q;
`endif

endmodule

// File: tb/tb_memory_word_access_unit.sv
// tb/tb_memory_word_access_unit.sv - randomized word access bench against a byte-array memory and word-level model
// MWAU_ALIGN_CHECK_EN selects the alignment-check build and a 3-cycle memory latency.
module tb_memory_word_access_unit;

`ifdef MWAU_ALIGN_CHECK_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memory_word_access_unit_if #(.ADDR_WIDTH(16)) bus ();

  memory_word_access_unit #(
    .ADDR_WIDTH  (16),
    .MEM_LATENCY (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [15:0] ref_rdata = 16'h0000;
  logic [15:0] addr_log [$];
  int          xact_cnt = 0;
  int          run      = 0;
  logic        prev_cs  = 1'b0;
  logic [15:0] prev_addr = 16'h0000;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Memory returns valid data only in the LAT-th cycle of a held access.
  always @(negedge clk) begin
    if (bus.mem_cs && prev_cs && bus.mem_addr == prev_addr) run++;
    else run = 0;
    prev_cs   = bus.mem_cs;
    prev_addr = bus.mem_addr;
    if (bus.mem_cs && run == 0) begin
      xact_cnt++;
      addr_log.push_back(bus.mem_addr);
    end
    if (bus.mem_cs && bus.mem_wr) mem[bus.mem_addr] = bus.mem_data_out;
    bus.mem_data_in = (bus.mem_cs && run == LAT - 1) ? mem[bus.mem_addr] : 8'($urandom);
  end

  task automatic do_op(input logic wr, input logic [15:0] a, input logic [15:0] wd, input bit poke);
    int          n;
    int          x0;
    bit          reject;
    logic [15:0] a1;
    logic [15:0] rd_before;
    a1        = a + 16'd1;
    reject    = 1'b0;
`ifdef MWAU_ALIGN_CHECK_EN
    reject    = a[0];
`endif
    rd_before = ref_rdata;
    x0        = xact_cnt;
    addr_log.delete();
    bus.start = 1'b1;
    bus.write = wr;
    bus.addr  = a;
    bus.wdata = wd;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.addr  = 16'($urandom);
    bus.wdata = 16'($urandom);
    bus.write = 1'($urandom);
    n = 1;
    if (!reject) check("busy_after_start", 32'(bus.busy), 32'd1);
    while (!bus.done && n < 40) begin
      bus.start = poke && (n == 2);
      @(posedge clk); #1;
      n++;
    end
    bus.start = 1'b0;
    if (reject) begin
`ifdef MWAU_ALIGN_CHECK_EN
      check("rej_align_err", 32'(bus.align_err), 32'd1);
`endif
      check("rej_latency", 32'(n), 32'd1);
      check("rej_no_access", 32'(xact_cnt - x0), 32'd0);
      check("rej_busy", 32'(bus.busy), 32'd0);
      check("rej_rdata", 32'(bus.rdata), 32'(rd_before));
    end else begin
      check("latency", 32'(n), 32'(2 * LAT + 1));
      check("byte_xacts", 32'(xact_cnt - x0), 32'd2);
      if (addr_log.size() == 2) begin
        check("addr_lo", 32'(addr_log[0]), 32'(a));
        check("addr_hi", 32'(addr_log[1]), 32'(a1));
      end else begin
        check("addr_log_size", 32'(addr_log.size()), 32'd2);
      end
      if (wr) begin
        ref_mem[a]  = wd[7:0];
        ref_mem[a1] = wd[15:8];
      end else begin
        ref_rdata = {ref_mem[a1], ref_mem[a]};
      end
      check("mem_bytes", 32'({mem[a1], mem[a]}), 32'({ref_mem[a1], ref_mem[a]}));
      check("rdata", 32'(bus.rdata), 32'(ref_rdata));
`ifdef MWAU_ALIGN_CHECK_EN
      check("align_err_clear", 32'(bus.align_err), 32'd0);
`endif
    end
    @(posedge clk); #1;
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  task automatic reset_mid_read(input logic [15:0] a);
    int n;
    int ndone;
    bus.start = 1'b1;
    bus.write = 1'b0;
    bus.addr  = a;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 1;
    while (n < LAT + 1) begin
      @(posedge clk); #1;
      n++;
    end
    check("pre_rst_hi_addr", 32'(bus.mem_addr), 32'(a + 16'd1));
    rst = 1'b1;
    #1;
    check("rst_cs", 32'(bus.mem_cs), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    ndone = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    rst = 1'b0;
    ref_rdata = 16'h0000;
    check("rst_no_done", 32'(ndone), 32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'd0);
  endtask

  initial begin
    logic [7:0] v;
    bus.start = 1'b0;
    bus.write = 1'b0;
    bus.addr  = 16'h0000;
    bus.wdata = 16'h0000;
    for (int i = 0; i < 65536; i++) begin
      v          = 8'($urandom);
      mem[i]     = v;
      ref_mem[i] = v;
    end
    mem[16'h0040] = 8'hCD; ref_mem[16'h0040] = 8'hCD;
    mem[16'h0041] = 8'hAB; ref_mem[16'h0041] = 8'hAB;

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_rdata", 32'(bus.rdata), 32'd0);
    check("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("reset_mem_data_out", 32'(bus.mem_data_out), 32'd0);
    check("reset_mem_cs", 32'(bus.mem_cs), 32'd0);
    check("reset_mem_wr", 32'(bus.mem_wr), 32'd0);
`ifdef MWAU_ALIGN_CHECK_EN
    check("reset_align_err", 32'(bus.align_err), 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(1'b0, 16'h0040, 16'h0000, 1'b0);
    check("read_abcd", 32'(bus.rdata), 32'h0000ABCD);
    do_op(1'b1, 16'h1000, 16'h1234, 1'b0);
    check("write_keeps_rdata", 32'(bus.rdata), 32'h0000ABCD);
    do_op(1'b0, 16'h1000, 16'h0000, 1'b0);
    do_op(1'b0, 16'hFFFF, 16'h0000, 1'b0);
    do_op(1'b0, 16'h0040, 16'h0000, 1'b1);
    do_op(1'b0, 16'h0041, 16'h0000, 1'b0);
    reset_mid_read(16'h2468);
    @(posedge clk); #1;
    do_op(1'b0, 16'h0040, 16'h0000, 1'b0);

    for (int k = 0; k < 24; k++) begin
      do_op(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
